// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared RV32 decode encodings for the decode stage.
// Revision : 1.0
// ============================================================================
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;
  localparam logic [1:0] RS_IMM = 2'b11;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/regfile_bypass_p.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bypass_p
// Brief    : 2R/1W register file, x0 and out-of-range indices read 0,
//            write-first bypass from the writeback port.
// Revision : 1.0
// ============================================================================
module regfile_bypass_p
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic            we,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  localparam int         c_aw    = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] c_nregs = 6'(NREGS);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_ok;
  logic            w_rs1_ok;
  logic            w_rs2_ok;

  // x0 is never stored; indices beyond NREGS neither write nor alias
  assign w_wr_ok  = ({1'b0, rd_w} < c_nregs) && (rd_w != 5'd0);
  assign w_rs1_ok = ({1'b0, rs1}  < c_nregs) && (rs1  != 5'd0);
  assign w_rs2_ok = ({1'b0, rs2}  < c_nregs) && (rs2  != 5'd0);

  always_ff @(posedge clk) begin
    if (we && w_wr_ok) begin
      r_regs[rd_w[c_aw-1:0]] <= result_w;
    end
  end

  always_comb begin
    rd1 = '0;
    if (w_rs1_ok) begin
      rd1 = (we && rd_w == rs1) ? result_w : r_regs[rs1[c_aw-1:0]];
    end
  end

  always_comb begin
    rd2 = '0;
    if (w_rs2_ok) begin
      rd2 = (we && rd_w == rs2) ? result_w : r_regs[rs2[c_aw-1:0]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage_p.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_p
// Brief    : RV32 decode stage with register file, immediate extension,
//            load-use detection and ID/EX register. Optional macro
//            DECODE_ILLEGAL_EN adds the registered illegal_e flag.
// Revision : 1.0
// ============================================================================
module decode_stage_p
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pcplus4_d,
  input  logic            valid_d,
  input  logic            flush_e,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic            stall_d,
  output logic            valid_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic            alu_src_e,
  output logic [1:0]      result_src_e,
  output logic [2:0]      alu_control_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pcplus4_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic            illegal_e
`endif
);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  ctrl_t           w_ctrl;
  imm_src_e        w_imm_src;
  logic            w_known;
  logic            w_use_f3;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm_ext;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic            w_bubble;

  ctrl_t           r_ctrl_e;
  logic            r_valid_e;
  logic [XLEN-1:0] r_rd1_e;
  logic [XLEN-1:0] r_rd2_e;
  logic [XLEN-1:0] r_imm_e;
  logic [XLEN-1:0] r_pc_e;
  logic [XLEN-1:0] r_pcplus4_e;
  logic [4:0]      r_rs1_e;
  logic [4:0]      r_rs2_e;
  logic [4:0]      r_rd_e;

  assign w_opcode = instr_d[6:0];
  assign w_rd     = instr_d[11:7];
  assign w_funct3 = instr_d[14:12];
  assign w_rs1    = instr_d[19:15];
  assign w_rs2    = instr_d[24:20];

  always_comb begin
    w_ctrl    = '0;
    w_imm_src = IMM_I;
    w_known   = 1'b1;
    w_use_f3  = 1'b0;
    case (w_opcode)
      OP_LOAD:   begin w_ctrl.reg_write = 1'b1; w_ctrl.result_src = RS_MEM; w_ctrl.alu_src = 1'b1; end
      OP_STORE:  begin w_ctrl.mem_write = 1'b1; w_ctrl.alu_src = 1'b1; w_imm_src = IMM_S; end
      OP_R:      begin w_ctrl.reg_write = 1'b1; w_use_f3 = 1'b1; end
      OP_I:      begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1; w_use_f3 = 1'b1; end
      OP_BRANCH: begin w_ctrl.branch = 1'b1; w_ctrl.alu_control = ALU_SUB; w_imm_src = IMM_B; end
      OP_JAL:    begin w_ctrl.jump = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.result_src = RS_PC4; w_imm_src = IMM_J; end
      OP_JALR:   begin w_ctrl.jump = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.result_src = RS_PC4; w_ctrl.alu_src = 1'b1; end
      OP_LUI:    begin w_ctrl.reg_write = 1'b1; w_ctrl.result_src = RS_IMM; w_imm_src = IMM_U; end
      OP_AUIPC:  begin w_ctrl.reg_write = 1'b1; w_imm_src = IMM_U; end
      default:   w_known = 1'b0;
    endcase
    // only ALU-class ops take their operation from funct3; addressing ops always add
    if (w_use_f3) begin
      case (w_funct3)
        3'b000:  w_ctrl.alu_control = (w_opcode == OP_R && instr_d[30]) ? ALU_SUB : ALU_ADD;
        3'b010:  w_ctrl.alu_control = ALU_SLT;
        3'b110:  w_ctrl.alu_control = ALU_OR;
        3'b111:  w_ctrl.alu_control = ALU_AND;
        default: w_ctrl.alu_control = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    case (w_imm_src)
      IMM_S:   w_imm32 = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      IMM_B:   w_imm32 = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
      IMM_J:   w_imm32 = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
      IMM_U:   w_imm32 = {instr_d[31:12], 12'b0};
      default: w_imm32 = {{20{instr_d[31]}}, instr_d[31:20]};
    endcase
  end

  assign w_imm_ext = XLEN'($signed(w_imm32));

  regfile_bypass_p #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rs1      (w_rs1),
    .rs2      (w_rs2),
    .we       (reg_write_w),
    .rd_w     (rd_w),
    .result_w (result_w),
    .rd1      (w_rd1),
    .rd2      (w_rd2)
  );

  // rs2 is compared even for formats without one: conservative on purpose
  assign stall_d = r_valid_e & (r_ctrl_e.result_src == RS_MEM) & (r_rd_e != 5'd0)
                 & ((r_rd_e == w_rs1) | (r_rd_e == w_rs2)) & valid_d;

  assign w_bubble = flush_e | stall_d | ~valid_d | ~w_known;

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_valid_e   <= 1'b0;
      r_ctrl_e    <= '0;
      r_rd1_e     <= '0;
      r_rd2_e     <= '0;
      r_imm_e     <= '0;
      r_pc_e      <= '0;
      r_pcplus4_e <= '0;
      r_rs1_e     <= '0;
      r_rs2_e     <= '0;
      r_rd_e      <= '0;
    end else begin
      r_valid_e   <= 1'b1;
      r_ctrl_e    <= w_ctrl;
      r_rd1_e     <= w_rd1;
      r_rd2_e     <= w_rd2;
      r_imm_e     <= w_imm_ext;
      r_pc_e      <= pc_d;
      r_pcplus4_e <= pcplus4_d;
      r_rs1_e     <= w_rs1;
      r_rs2_e     <= w_rs2;
      r_rd_e      <= w_rd;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  logic r_illegal_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal_e <= 1'b0;
    end else begin
      r_illegal_e <= valid_d & ~stall_d & ~flush_e & ~w_known;
    end
  end

  assign illegal_e = r_illegal_e;
`else
  // undecoded opcodes fall into the bubble path with no side flag
`endif

  assign valid_e       = r_valid_e;
  assign reg_write_e   = r_ctrl_e.reg_write;
  assign mem_write_e   = r_ctrl_e.mem_write;
  assign branch_e      = r_ctrl_e.branch;
  assign jump_e        = r_ctrl_e.jump;
  assign alu_src_e     = r_ctrl_e.alu_src;
  assign result_src_e  = r_ctrl_e.result_src;
  assign alu_control_e = r_ctrl_e.alu_control;
  assign rd1_e         = r_rd1_e;
  assign rd2_e         = r_rd2_e;
  assign imm_ext_e     = r_imm_e;
  assign pc_e          = r_pc_e;
  assign pcplus4_e     = r_pcplus4_e;
  assign rs1_e         = r_rs1_e;
  assign rs2_e         = r_rs2_e;
  assign rd_e          = r_rd_e;

endmodule
`default_nettype wire
